// File: rtl/box_cmd_rx.sv
// box_cmd_rx: receives draw-box command packets from the UDP RX byte stream,
// validates them, and double-buffers the decoded boxes (shadow -> pending ->
// active) so new boxes only become visible at a frame boundary.
//
// Packet: MAGIC, n, then n 6-byte big-endian records
//   [47:37] x0, [36:27] y0, [26:16] x1, [15:6] y1, [5:0] {r2,g2,b2}
//
// Ports
//   clk, rst          clock (rgmii_clk), synchronous active-high reset
//   rx_valid/rx_data  one payload byte per cycle
//   rx_data_len       payload length, stable for the whole packet
//   frame_sync        1-cycle frame-start pulse (already in clk domain)
//   start_xs/start_ys/end_xs/end_ys/colors
//                     active box set, box k at [k*W +: W]
//   cmd_ok            pulse: packet accepted into pending
//   cmd_err           pulse: packet rejected
//   err_code          cause of last rejection
//                     (1 magic, 2 count, 3 length, 4 range, 5 timeout)
module box_cmd_rx #(
  parameter int unsigned N_BOX   = 1,
  parameter int unsigned H_ACT   = 1280,
  parameter int unsigned V_ACT   = 720,
  parameter logic [7:0]  MAGIC   = 8'hAB,
  parameter int unsigned TIMEOUT = 4096,
  localparam int unsigned XW = $clog2(H_ACT),
  localparam int unsigned YW = $clog2(V_ACT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic [15:0]         rx_data_len,
  input  logic                frame_sync,
  output logic [N_BOX*XW-1:0] start_xs,
  output logic [N_BOX*YW-1:0] start_ys,
  output logic [N_BOX*XW-1:0] end_xs,
  output logic [N_BOX*YW-1:0] end_ys,
  output logic [N_BOX*24-1:0] colors,
  output logic                cmd_ok,
  output logic                cmd_err,
  output logic [2:0]          err_code
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BOX, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_nxt;

  logic [15:0]         r_cnt;
  logic [7:0]          r_n;
  logic [7:0]          r_idx;
  logic [2:0]          r_bcnt;
  logic [39:0]         r_word;
  logic [2:0]          r_drain_code;
  logic [TW-1:0]       r_idle;
  logic                r_pend;
  logic [N_BOX*XW-1:0] r_sh_sx, r_sh_ex, r_pd_sx, r_pd_ex;
  logic [N_BOX*YW-1:0] r_sh_sy, r_sh_ey, r_pd_sy, r_pd_ey;
  logic [N_BOX*24-1:0] r_sh_col, r_pd_col;

  logic        w_last, w_timeout, w_rec_ok;
  logic        w_fire_err, w_to_drain, w_wr_slot;
  logic [2:0]  w_code, w_err_val;
  logic [47:0] w_rec;
  logic [10:0] w_x0, w_x1;
  logic [9:0]  w_y0, w_y1;
  logic [23:0] w_col;
  logic [16:0] w_need_len;

  // >= rather than == so that lengths 0 and 1 both end the packet at byte 0
  assign w_last     = ({1'b0, r_cnt} + 17'd1) >= {1'b0, rx_data_len};
  assign w_timeout  = !rx_valid && (r_idle == TW'(TIMEOUT - 1));
  assign w_need_len = 17'd2 + 17'(rx_data) * 17'd6;

  assign w_rec = {r_word, rx_data};
  assign w_x0  = w_rec[47:37];
  assign w_y0  = w_rec[36:27];
  assign w_x1  = w_rec[26:16];
  assign w_y1  = w_rec[15:6];
  assign w_col = {{4{w_rec[5:4]}}, {4{w_rec[3:2]}}, {4{w_rec[1:0]}}};
  assign w_rec_ok = (w_x0 <= w_x1) && (32'(w_x1) < H_ACT) &&
                    (w_y0 <= w_y1) && (32'(w_y1) < V_ACT);

  always_comb begin
    w_nxt      = r_state;
    w_code     = '0;
    w_fire_err = 1'b0;
    w_err_val  = '0;
    w_to_drain = 1'b0;
    w_wr_slot  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data != MAGIC) w_code = 3'd1;
          else if (w_last)      w_code = 3'd3;
          else                  w_nxt  = S_HDR;
        end
      end
      S_HDR: begin
        if (rx_valid) begin
          if (32'(rx_data) > N_BOX)                   w_code = 3'd2;
          else if ({1'b0, rx_data_len} != w_need_len) w_code = 3'd3;
          else if (rx_data == 8'd0)                   w_nxt  = S_DONE;
          else                                        w_nxt  = S_BOX;
        end else if (w_timeout) begin
          w_fire_err = 1'b1;
          w_err_val  = 3'd5;
          w_nxt      = S_IDLE;
        end
      end
      S_BOX: begin
        if (rx_valid) begin
          if (r_bcnt == 3'd5) begin
            if (!w_rec_ok) w_code = 3'd4;
            else begin
              w_wr_slot = 1'b1;
              if (r_idx + 8'd1 == r_n) w_nxt = S_DONE;
            end
          end
        end else if (w_timeout) begin
          w_fire_err = 1'b1;
          w_err_val  = 3'd5;
          w_nxt      = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (rx_valid) begin
          if (w_last) begin
            w_fire_err = 1'b1;
            w_err_val  = r_drain_code;
            w_nxt      = S_IDLE;
          end
        end else if (w_timeout) begin
          w_fire_err = 1'b1;
          w_err_val  = 3'd5;
          w_nxt      = S_IDLE;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    // An error on the packet's final byte is reported at once; otherwise the
    // rest of the packet is drained and the error reported at its end.
    if (w_code != '0) begin
      if (w_last) begin
        w_fire_err = 1'b1;
        w_err_val  = w_code;
        w_nxt      = S_IDLE;
      end else begin
        w_to_drain = 1'b1;
        w_nxt      = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_n          <= '0;
      r_idx        <= '0;
      r_bcnt       <= '0;
      r_word       <= '0;
      r_drain_code <= '0;
      r_idle       <= '0;
      r_pend       <= 1'b0;
      r_sh_sx      <= '0;
      r_sh_sy      <= '0;
      r_sh_ex      <= '0;
      r_sh_ey      <= '0;
      r_sh_col     <= '0;
      r_pd_sx      <= '0;
      r_pd_sy      <= '0;
      r_pd_ex      <= '0;
      r_pd_ey      <= '0;
      r_pd_col     <= '0;
      start_xs     <= '0;
      start_ys     <= '0;
      end_xs       <= '0;
      end_ys       <= '0;
      colors       <= '0;
      cmd_ok       <= 1'b0;
      cmd_err      <= 1'b0;
      err_code     <= '0;
    end else begin
      r_state <= w_nxt;
      cmd_ok  <= 1'b0;
      cmd_err <= w_fire_err;
      if (w_fire_err) err_code <= w_err_val;
      if (w_to_drain) r_drain_code <= w_code;

      if (rx_valid || r_state == S_IDLE || r_state == S_DONE) r_idle <= '0;
      else                                                    r_idle <= r_idle + 1'b1;

      if (w_nxt == S_IDLE || w_nxt == S_DONE) r_cnt <= '0;
      else if (rx_valid)                      r_cnt <= r_cnt + 16'd1;

      // Shadow is wiped at every packet start so unused slots end up disabled
      if (r_state == S_IDLE && rx_valid) begin
        r_sh_sx  <= '0;
        r_sh_sy  <= '0;
        r_sh_ex  <= '0;
        r_sh_ey  <= '0;
        r_sh_col <= '0;
        r_idx    <= '0;
        r_bcnt   <= '0;
      end
      if (r_state == S_HDR && rx_valid) r_n <= rx_data;
      if (r_state == S_BOX && rx_valid) begin
        r_word <= w_rec[39:0];
        r_bcnt <= (r_bcnt == 3'd5) ? 3'd0 : r_bcnt + 3'd1;
      end
      if (w_wr_slot) begin
        for (int unsigned k = 0; k < N_BOX; k++) begin
          if (r_idx == 8'(k)) begin
            r_sh_sx[k*XW +: XW]  <= XW'(w_x0);
            r_sh_sy[k*YW +: YW]  <= YW'(w_y0);
            r_sh_ex[k*XW +: XW]  <= XW'(w_x1);
            r_sh_ey[k*YW +: YW]  <= YW'(w_y1);
            r_sh_col[k*24 +: 24] <= w_col;
          end
        end
        r_idx <= r_idx + 8'd1;
      end

      // Commit precedes the DONE load so a coinciding DONE lands in pending
      // and waits for the next frame_sync.
      if (frame_sync && r_pend) begin
        start_xs <= r_pd_sx;
        start_ys <= r_pd_sy;
        end_xs   <= r_pd_ex;
        end_ys   <= r_pd_ey;
        colors   <= r_pd_col;
        r_pend   <= 1'b0;
      end
      if (r_state == S_DONE) begin
        r_pd_sx  <= r_sh_sx;
        r_pd_sy  <= r_sh_sy;
        r_pd_ex  <= r_sh_ex;
        r_pd_ey  <= r_sh_ey;
        r_pd_col <= r_sh_col;
        r_pend   <= 1'b1;
        cmd_ok   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_box_cmd_rx.sv
module tb_box_cmd_rx;
  localparam int N_BOX   = 1;
  localparam int H_ACT   = 1280;
  localparam int V_ACT   = 720;
  localparam int TIMEOUT = 4096;
  localparam int XW      = 11;
  localparam int YW      = 10;

  logic          clk = 1'b0;
  logic          rst, rx_valid, frame_sync;
  logic [7:0]    rx_data;
  logic [15:0]   rx_data_len;
  logic [XW-1:0] start_xs, end_xs;
  logic [YW-1:0] start_ys, end_ys;
  logic [23:0]   colors;
  logic          cmd_ok, cmd_err;
  logic [2:0]    err_code;

  typedef struct packed {
    logic [10:0] x0;
    logic [9:0]  y0;
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [23:0] col;
  } box_t;

  logic [65:0] obs;
  assign obs = {start_xs, start_ys, end_xs, end_ys, colors};

  int errors = 0;
  int checks = 0;
  int n_ok   = 0;

  byte unsigned pkt[$];
  box_t exp_act, exp_pend, bx;
  bit   exp_pflag;

  always #5 clk = ~clk;
  always @(negedge clk) if (cmd_ok === 1'b1) n_ok++;

  box_cmd_rx #(.N_BOX(N_BOX), .H_ACT(H_ACT), .V_ACT(V_ACT), .MAGIC(8'hAB), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_data_len(rx_data_len),
    .frame_sync(frame_sync), .start_xs(start_xs), .start_ys(start_ys), .end_xs(end_xs),
    .end_ys(end_ys), .colors(colors), .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One packet with a single record: MAGIC, n=1, 6 record bytes
  task automatic build(input int x0, input int y0, input int x1, input int y1, input int c);
    logic [63:0] w;
    w = (64'(x0 & 2047) << 37) | (64'(y0 & 1023) << 27) | (64'(x1 & 2047) << 16) |
        (64'(y1 & 1023) << 6) | 64'(c & 63);
    pkt = {};
    pkt.push_back(8'hAB);
    pkt.push_back(8'h01);
    for (int j = 5; j >= 0; j--) pkt.push_back(8'(w >> (8 * j)));
  endtask

  task automatic send(input int len);
    rx_data_len = 16'(len);
    foreach (pkt[i]) begin
      rx_valid = 1'b1;
      rx_data  = pkt[i];
      step();
    end
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  // Reference: outcome of a complete packet held in pkt (0 = accepted)
  function automatic int model(input int len, output box_t b);
    logic [63:0] w;
    int n, x0, y0, x1, y1, c;
    b = '0;
    if (pkt[0] != 8'hAB) return 1;
    if (len < 2) return 3;
    n = int'(pkt[1]);
    if (n > N_BOX) return 2;
    if (len != 2 + 6 * n) return 3;
    for (int r = 0; r < n; r++) begin
      w = '0;
      for (int j = 0; j < 6; j++) w = (w << 8) | 64'(pkt[2 + 6 * r + j]);
      x0 = int'((w >> 37) & 64'd2047);
      y0 = int'((w >> 27) & 64'd1023);
      x1 = int'((w >> 16) & 64'd2047);
      y1 = int'((w >> 6) & 64'd1023);
      c  = int'(w & 64'd63);
      if (!(x0 <= x1 && x1 < H_ACT && y0 <= y1 && y1 < V_ACT)) return 4;
      b.x0  = 11'(x0);
      b.y0  = 10'(y0);
      b.x1  = 11'(x1);
      b.y1  = 10'(y1);
      b.col = {8'(((c >> 4) & 3) * 85), 8'(((c >> 2) & 3) * 85), 8'((c & 3) * 85)};
    end
    return 0;
  endfunction

  task automatic frame();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    if (exp_pflag) begin
      exp_act   = exp_pend;
      exp_pflag = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_data_len = '0; frame_sync = 1'b0;
    repeat (3) step();
    exp_act = '0; exp_pend = '0; exp_pflag = 1'b0;
    checks++; if (obs !== 66'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    checks++; if ({cmd_ok, cmd_err, err_code} !== 5'd0) begin errors++; $display("FAIL reset_status: got %b expected 00000", {cmd_ok, cmd_err, err_code}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_good_packet();
    int code;
    build(100, 50, 200, 150, 6'b110000);
    code = model(8, bx);
    send(8);
    checks++; if (cmd_ok !== 1'b0) begin errors++; $display("FAIL t1_ok_early: got %b expected 0", cmd_ok); end
    step();
    checks++; if (cmd_ok !== 1'b1 || code != 0) begin errors++; $display("FAIL t1_ok_latency: got %b expected 1", cmd_ok); end
    exp_pend = bx; exp_pflag = 1'b1;
    step();
    checks++; if (cmd_ok !== 1'b0) begin errors++; $display("FAIL t1_ok_pulse: got %b expected 0", cmd_ok); end
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t1_hold_before_frame: got %h expected %h", obs, exp_act); end
    frame();
    checks++; if (start_xs !== 11'd100 || end_ys !== 10'd150 || colors !== 24'hFF0000) begin
      errors++; $display("FAIL t1_commit: got sx=%0d ey=%0d col=%h expected 100 150 ff0000", start_xs, end_ys, colors); end
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t1_commit_model: got %h expected %h", obs, exp_act); end
  endtask

  task automatic test_bad_magic();
    build(10, 10, 20, 20, 6'h3F);
    pkt[0] = 8'hAC;
    send(8);
    checks++; if (cmd_err !== 1'b1 || err_code !== 3'd1) begin errors++; $display("FAIL t2_magic: got err=%b code=%0d expected 1 1", cmd_err, err_code); end
    step();
    frame();
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t2_outputs: got %h expected %h", obs, exp_act); end
  endtask

  task automatic test_range();
    int code;
    build(300, 400, 900, 700, 6'b000111);
    code = model(8, bx);
    send(8); step();
    checks++; if (cmd_ok !== 1'b1 || code != 0) begin errors++; $display("FAIL t3_setup_ok: got %b expected 1", cmd_ok); end
    exp_pend = bx; exp_pflag = 1'b1;
    step();
    build(0, 0, 1280, 10, 6'h15);
    send(8);
    checks++; if (cmd_err !== 1'b1 || err_code !== 3'd4) begin errors++; $display("FAIL t3_range: got err=%b code=%0d expected 1 4", cmd_err, err_code); end
    step();
    frame();
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t3_pending_kept: got %h expected %h", obs, exp_act); end
  endtask

  task automatic test_lengths();
    build(1, 1, 2, 2, 6'h01);
    pkt.push_back(8'h55);
    send(9);
    checks++; if (cmd_err !== 1'b1 || err_code !== 3'd3) begin errors++; $display("FAIL t4_len9: got err=%b code=%0d expected 1 3", cmd_err, err_code); end
    step();
    pkt = {8'hAB};
    send(1);
    checks++; if (cmd_err !== 1'b1 || err_code !== 3'd3) begin errors++; $display("FAIL len1_magic: got err=%b code=%0d expected 1 3", cmd_err, err_code); end
    step();
    pkt = {8'hAB};
    send(0);
    checks++; if (cmd_err !== 1'b1 || err_code !== 3'd3) begin errors++; $display("FAIL len0: got err=%b code=%0d expected 1 3", cmd_err, err_code); end
    step();
    build(1, 1, 2, 2, 6'h01);
    pkt[1] = 8'h02;
    repeat (6) pkt.push_back(8'h00);
    send(14);
    checks++; if (cmd_err !== 1'b1 || err_code !== 3'd2) begin errors++; $display("FAIL n_too_big: got err=%b code=%0d expected 1 2", cmd_err, err_code); end
    step();
  endtask

  task automatic test_boundary();
    int code;
    build(1279, 719, 1279, 719, 6'b011011);
    code = model(8, bx);
    send(8); step();
    checks++; if (cmd_ok !== 1'b1 || code != 0) begin errors++; $display("FAIL edge_accept: got %b expected 1", cmd_ok); end
    exp_pend = bx; exp_pflag = 1'b1;
    step(); frame();
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL edge_commit: got %h expected %h", obs, exp_act); end
    pkt = {8'hAB, 8'h00};
    send(2); step();
    checks++; if (cmd_ok !== 1'b1) begin errors++; $display("FAIL n0_accept: got %b expected 1", cmd_ok); end
    exp_pend = '0; exp_pflag = 1'b1;
    step(); frame();
    checks++; if (obs !== 66'd0) begin errors++; $display("FAIL n0_disables: got %h expected 0", obs); end
    exp_act = '0;
  endtask

  task automatic test_timeout();
    int k, code;
    build(5, 6, 7, 8, 6'h2A);
    pkt = pkt[0:2];
    send(8);
    k = 0;
    while (cmd_err !== 1'b1 && k < TIMEOUT + 100) begin step(); k++; end
    checks++; if (k != TIMEOUT) begin errors++; $display("FAIL t5_timeout_cycles: got %0d expected %0d", k, TIMEOUT); end
    checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL t5_timeout_code: got %0d expected 5", err_code); end
    step();
    build(5, 6, 7, 8, 6'h2A);
    code = model(8, bx);
    send(8); step();
    checks++; if (cmd_ok !== 1'b1 || code != 0) begin errors++; $display("FAIL t5_recover: got %b expected 1", cmd_ok); end
    exp_pend = bx; exp_pflag = 1'b1;
    step(); frame();
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t5_recover_out: got %h expected %h", obs, exp_act); end
  endtask

  task automatic test_back_to_back();
    box_t a, b;
    int ca, cb;
    build(10, 20, 30, 40, 6'b110011); ca = model(8, a);
    send(8); step(); step();
    build(50, 60, 70, 80, 6'b001100); cb = model(8, b);
    send(8); step();
    checks++; if (cmd_ok !== 1'b1 || ca != 0 || cb != 0) begin errors++; $display("FAIL t6_b_ok: got %b expected 1", cmd_ok); end
    exp_pend = b; exp_pflag = 1'b1;
    step(); frame();
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t6_last_wins: got %h expected %h", obs, exp_act); end
    build(111, 222, 333, 444, 6'b010101); ca = model(8, a);
    send(8); step(); step();
    exp_pend = a; exp_pflag = 1'b1;
    build(600, 100, 1000, 600, 6'b100110); cb = model(8, b);
    send(8);
    frame();
    exp_pend = b; exp_pflag = 1'b1;
    checks++; if (cmd_ok !== 1'b1) begin errors++; $display("FAIL t6_coincide_ok: got %b expected 1", cmd_ok); end
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t6_coincide_old: got %h expected %h", obs, exp_act); end
    step(); frame();
    checks++; if (obs !== exp_act) begin errors++; $display("FAIL t6_coincide_next: got %h expected %h", obs, exp_act); end
  endtask

  task automatic test_reset_mid();
    int k, ok0;
    build(64, 32, 640, 320, 6'h30);
    ok0 = n_ok;
    rx_data_len = 16'd8;
    for (int i = 0; i < 5; i++) begin rx_valid = 1'b1; rx_data = pkt[i]; step(); end
    rst = 1'b1; rx_data = pkt[5]; step();
    rst = 1'b0;
    exp_act = '0; exp_pend = '0; exp_pflag = 1'b0;
    checks++; if (obs !== 66'd0) begin errors++; $display("FAIL t7_outputs: got %h expected 0", obs); end
    pkt = pkt[6:7];
    send(8);
    k = 0;
    while (cmd_err !== 1'b1 && k < TIMEOUT + 100) begin step(); k++; end
    checks++; if (cmd_err !== 1'b1 || err_code !== 3'd5) begin errors++; $display("FAIL t7_leftover: got err=%b code=%0d expected 1 5", cmd_err, err_code); end
    step(); frame();
    checks++; if (n_ok != ok0) begin errors++; $display("FAIL t7_no_ok: got %0d expected %0d", n_ok, ok0); end
    checks++; if (obs !== 66'd0) begin errors++; $display("FAIL t7_after_frame: got %h expected 0", obs); end
  endtask

  task automatic test_random();
    int kind, len, code, x0, y0, x1, y1;
    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 4));
      x0 = int'($urandom_range(0, 1279)); x1 = int'($urandom_range(x0, 1279));
      y0 = int'($urandom_range(0, 719));  y1 = int'($urandom_range(y0, 719));
      if (kind == 2) begin
        x0 = int'($urandom_range(0, 1400)); x1 = int'($urandom_range(0, 1400));
        y0 = int'($urandom_range(0, 800));  y1 = int'($urandom_range(0, 800));
      end
      build(x0, y0, x1, y1, int'($urandom_range(0, 63)));
      len = 8;
      if (kind == 1) begin
        pkt[0] = 8'($urandom_range(0, 255));
        if (pkt[0] == 8'hAB) pkt[0] = 8'hAA;
      end else if (kind == 3) begin
        len = int'($urandom_range(2, 14));
        if (len == 8) len = 9;
        while (pkt.size() < len) pkt.push_back(8'($urandom_range(0, 255)));
        while (pkt.size() > len) void'(pkt.pop_back());
      end else if (kind == 4) begin
        pkt = {8'hAB, 8'h00};
        len = 2;
      end
      code = model(len, bx);
      send(len);
      if (code == 0) begin
        step();
        checks++; if (cmd_ok !== 1'b1) begin errors++; $display("FAIL rand_ok[%0d]: got %b expected 1", it, cmd_ok); end
        exp_pend = bx; exp_pflag = 1'b1;
      end else begin
        checks++; if (cmd_err !== 1'b1 || err_code !== 3'(code)) begin
          errors++; $display("FAIL rand_err[%0d]: got err=%b code=%0d expected 1 %0d", it, cmd_err, err_code, code); end
      end
      step();
      if ($urandom_range(0, 1) == 1) frame();
      checks++; if (obs !== exp_act) begin errors++; $display("FAIL rand_out[%0d]: got %h expected %h", it, obs, exp_act); end
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_magic();
    test_range();
    test_lengths();
    test_boundary();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
